jt5205_adpcm: RTL and testbench

- Cycle-accurate model of the OKI MSM5205 4-bit ADPCM speech decoder.
- Sits between a sample-fetch engine and the audio mixer.
- Generates the sample-request timing from a clock enable, consumes one 4-bit ADPCM nibble per sample period, and outputs a 12-bit signed PCM value.

---
 rtl/jt5205_pkg.sv | 39 +++
 rtl/jt5205_dec.sv | 48 ++++
 rtl/jt5205_adpcm.sv | 110 +++++++++++
 tb/tb_jt5205_adpcm.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/jt5205_pkg.sv
`timescale 1ns/1ps
// Shared constants for the MSM5205 ADPCM decoder: step table, index adjust
// table, divider ratios and sel encodings.
package jt5205_pkg;

  localparam logic [6:0] DIV_96 = 7'd96;
  localparam logic [6:0] DIV_48 = 7'd48;
  localparam logic [6:0] DIV_64 = 7'd64;

  localparam logic [1:0] SEL_96   = 2'b00;
  localparam logic [1:0] SEL_48   = 2'b01;
  localparam logic [1:0] SEL_64   = 2'b10;
  localparam logic [1:0] SEL_HALT = 2'b11;

  localparam int IDX_MAX = 48;

  localparam logic [10:0] STEP_TBL [49] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  localparam logic signed [7:0] IDX_ADJ [8] = '{
    -8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd2, 8'sd4, 8'sd6, 8'sd8
  };

  function automatic logic [6:0] div_n(input logic [1:0] sel);
    case (sel)
      SEL_48:  div_n = DIV_48;
      SEL_64:  div_n = DIV_64;
      default: div_n = DIV_96;
    endcase
  endfunction

endpackage

// File: rtl/jt5205_dec.sv
`timescale 1ns/1ps
// One ADPCM decode step: nibble + accumulator + step index -> next
// accumulator (saturated to 12 bits) and next step index (clamped 0..48).
module jt5205_dec
  import jt5205_pkg::*;
(
  input  logic [3:0]         din,
  input  logic signed [11:0] acc,
  input  logic [5:0]         idx,
  output logic signed [11:0] acc_next,
  output logic [5:0]         idx_next
);

  logic [11:0]        w_step;
  logic [11:0]        w_diff;
  logic signed [13:0] w_sum;
  logic signed [7:0]  w_idx;

  always_comb begin
    w_step = {1'b0, STEP_TBL[idx]};
    w_diff = (w_step >> 3)
           + (din[2] ? w_step        : 12'd0)
           + (din[1] ? (w_step >> 1) : 12'd0)
           + (din[0] ? (w_step >> 2) : 12'd0);

    // Wide enough that acc +/- the largest diff cannot wrap before clamping.
    if (din[3])
      w_sum = $signed({{2{acc[11]}}, acc}) - $signed({2'b00, w_diff});
    else
      w_sum = $signed({{2{acc[11]}}, acc}) + $signed({2'b00, w_diff});

    if (w_sum > 14'sd2047)
      acc_next = 12'sd2047;
    else if (w_sum < -14'sd2048)
      acc_next = -12'sd2048;
    else
      acc_next = w_sum[11:0];

    w_idx = $signed({2'b00, idx}) + IDX_ADJ[din[2:0]];
    if (w_idx < 8'sd0)
      idx_next = 6'd0;
    else if (w_idx > 8'(IDX_MAX))
      idx_next = 6'(IDX_MAX);
    else
      idx_next = w_idx[5:0];
  end

endmodule

// File: rtl/jt5205_adpcm.sv
`timescale 1ns/1ps
// MSM5205 ADPCM decoder: sample-rate divider driven by cen, one nibble
// decoded per sample event, optional output slew interpolation.
module jt5205_adpcm
  import jt5205_pkg::*;
#(
  parameter int INTERPOL = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cen,
  input  logic [1:0]         sel,
  input  logic [3:0]         din,
  output logic signed [11:0] sound,
  output logic               sample,
  output logic               irq,
  output logic               vclk_o
);

  logic [6:0]         r_cnt;
  logic [1:0]         r_sel;
  logic               r_vclk;
  logic signed [11:0] r_acc;
  logic [5:0]         r_idx;
  logic signed [11:0] r_sound;

  logic               w_halt;
  logic               w_wrap;
  logic               w_event;
  logic [6:0]         w_n;
  logic signed [11:0] w_acc_next;
  logic [5:0]         w_idx_next;

  assign w_halt  = (sel == SEL_HALT);
  assign w_n     = div_n(r_sel);
  assign w_wrap  = (r_cnt == w_n - 7'd1);
  assign w_event = cen && !w_halt && w_wrap && !reset;

  // The ratio in r_sel only changes at a wrap so a period always completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= 7'd0;
      r_sel  <= sel;
      r_vclk <= 1'b0;
    end else begin
      if (r_sel == SEL_HALT && !w_halt)
        r_sel <= sel;
      if (cen && !w_halt) begin
        if (w_wrap) begin
          r_cnt  <= 7'd0;
          r_sel  <= sel;
          r_vclk <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + 7'd1;
          r_vclk <= (r_cnt + 7'd1) < (w_n >> 1);
        end
      end
    end
  end

  jt5205_dec u_dec (
    .din      (din),
    .acc      (r_acc),
    .idx      (r_idx),
    .acc_next (w_acc_next),
    .idx_next (w_idx_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= 12'sd0;
      r_idx <= 6'd0;
    end else if (w_event) begin
      r_acc <= w_acc_next;
      r_idx <= w_idx_next;
    end
  end

  generate
    if (INTERPOL == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (reset)
          r_sound <= 12'sd0;
        else
          r_sound <= r_acc;
      end
    end else begin : g_slew
      logic signed [12:0] w_delta;
      logic signed [12:0] w_slew;
      assign w_delta = $signed({r_acc[11], r_acc}) - $signed({r_sound[11], r_sound});
      assign w_slew  = w_delta >>> 2;
      always_ff @(posedge clk) begin
        if (reset)
          r_sound <= 12'sd0;
        else if (cen && !w_halt) begin
          if (w_delta > -13'sd4 && w_delta < 13'sd4)
            r_sound <= r_acc;
          else
            r_sound <= r_sound + w_slew[11:0];
        end
      end
    end
  endgenerate

  assign sound  = r_sound;
  assign sample = w_event;
  assign vclk_o = r_vclk;
  assign irq    = r_vclk;

endmodule

// File: tb/tb_jt5205_adpcm.sv
`timescale 1ns/1ps
// Directed bench for jt5205_adpcm: divider timing, decode values,
// saturation, halt and mid-stream reset.
module tb_jt5205_adpcm;

  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic               cen   = 1'b0;
  logic [1:0]         sel   = 2'b01;
  logic [3:0]         din   = 4'd0;
  logic signed [11:0] sound;
  logic               sample;
  logic               irq;
  logic               vclk_o;

  int n_total = 0;
  int n_bad   = 0;

  jt5205_adpcm #(.INTERPOL(0)) dut (
    .clk    (clk),
    .reset  (reset),
    .cen    (cen),
    .sel    (sel),
    .din    (din),
    .sound  (sound),
    .sample (sample),
    .irq    (irq),
    .vclk_o (vclk_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One cen pulse; p reports whether sample fired during it. Returns one clk
  // after the cen edge so a freshly decoded value is already on sound.
  task automatic step_cen(output logic p);
    cen = 1'b1;
    @(negedge clk);
    p = sample;
    @(posedge clk); #1;
    cen = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_event(input int maxc, output int n, output int hi);
    logic p;
    p  = 1'b0;
    n  = 0;
    hi = 0;
    while (!p && n < maxc) begin
      step_cen(p);
      n++;
      if (vclk_o) hi++;
    end
  endtask

  task automatic do_reset(input logic [1:0] s);
    reset = 1'b1;
    sel   = s;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic ev(input string tag, input logic [3:0] d, input int want_snd, input int want_idx);
    int n, hi;
    din = d;
    run_event(200, n, hi);
    chk({tag, ".snd"}, sound, want_snd);
    chk({tag, ".idx"}, int'(dut.r_idx), want_idx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hi, pulses;
    logic p;
    int up_snd [7] = '{30, 93, 229, 522, 1153, 2047, 2047};
    int up_idx [7] = '{8, 16, 24, 32, 40, 48, 48};

    @(posedge clk); #1;

    // reset state and first event timing, sel=01
    do_reset(2'b01);
    chk("rst.sound", sound, 0);
    chk("rst.vclk", vclk_o, 0);
    chk("rst.sample", sample, 0);
    chk("rst.irq", irq, 0);
    din = 4'b0000;
    run_event(200, n, hi);
    chk("first.n", n, 48);
    chk("first.snd", sound, 2);
    chk("first.idx", int'(dut.r_idx), 0);
    chk("first.vclk", vclk_o, 1);

    do_reset(2'b01);
    ev("p7a", 4'b0111, 30, 8);
    ev("p7b", 4'b0111, 93, 16);

    // negative direction and low saturation
    do_reset(2'b01);
    ev("n8", 4'b1000, -2, 0);
    din = 4'b1111;
    for (int i = 0; i < 6; i++) run_event(200, n, hi);
    chk("nsat.snd", sound, -2048);
    chk("nsat.idx", int'(dut.r_idx), 48);
    ev("nsat2", 4'b1111, -2048, 48);
    ev("nsat3", 4'b1111, -2048, 48);

    // positive ramp to 2047, then a small step with index decrement
    do_reset(2'b01);
    for (int i = 0; i < 7; i++) ev($sformatf("up%0d", i), 4'b0111, up_snd[i], up_idx[i]);
    ev("up_zero", 4'b0000, 2047, 47);

    // sel change mid-period: old ratio finishes first
    sel = 2'b00;
    run_event(200, n, hi);
    chk("selchg.old_n", n, 48);
    run_event(200, n, hi);
    chk("selchg.new_n", n, 96);
    chk("selchg.hi", hi, 48);

    do_reset(2'b00);
    run_event(200, n, hi);
    chk("div96.first_n", n, 96);

    do_reset(2'b10);
    run_event(200, n, hi);
    chk("div64.first_n", n, 64);
    run_event(200, n, hi);
    chk("div64.n", n, 64);
    chk("div64.hi", hi, 32);

    // halt: no pulses, sound frozen, resumes where it stopped
    do_reset(2'b01);
    ev("pre_halt", 4'b0111, 30, 8);
    sel = 2'b11;
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      step_cen(p);
      if (p) pulses++;
    end
    chk("halt.pulses", pulses, 0);
    chk("halt.snd", sound, 30);
    sel = 2'b01;
    run_event(200, n, hi);
    chk("resume.n", n, 48);
    chk("resume.snd", sound, 93);

    // reset held mid-stream
    for (int i = 0; i < 10; i++) step_cen(p);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst.snd", sound, 0);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b0;
    din = 4'b0000;
    run_event(200, n, hi);
    chk("midrst.n", n, 48);
    chk("midrst.snd2", sound, 2);
    chk("midrst.idx", int'(dut.r_idx), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
